// File: rtl/wb_wide_pkg.sv
// wb_wide_pkg: shared FSM states and Wishbone word/select widths for the wide reader.
package wb_wide_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  localparam int WORD_W = 32;
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_ALL = '1;
endpackage

// File: rtl/wb_wide_timeout.sv
// wb_wide_timeout: counts idle bus cycles and flags expiry once TIMEOUT is reached.
module wb_wide_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb begin
    expired_o = cnt_q == TW'(TIMEOUT);
    cnt_d = clear_i ? '0 : (enable_i & ~expired_o) ? cnt_q + TW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_wide_reader.sv
// wb_wide_reader: request-driven Wishbone pipelined master doing NWORDS-beat reads or single writes.
module wb_wide_reader
  import wb_wide_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NWORDS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDR_WIDTH-3:0]    req_adr_i,
  input  logic [WORD_W-1:0]        req_wdat_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [WORD_W*NWORDS-1:0] rsp_data_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic                     wb_we_o,
  output logic [ADDR_WIDTH-3:0]    wb_adr_o,
  output logic [SEL_W-1:0]         wb_sel_o,
  output logic [WORD_W-1:0]        wb_dat_o,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic                     wb_stall_i,
  input  logic [WORD_W-1:0]        wb_dat_i
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int CW = $clog2(NWORDS + 1);
  localparam int DW = WORD_W * NWORDS;
  state_e state_q, state_d;
  logic we_q, we_d, cyc_q, cyc_d, stb_q, stb_d, err_q, err_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [WORD_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CW-1:0] iss_q, iss_d, ack_q, ack_d, n;
  logic [DW-1:0] data_q, data_d;
  logic hs, busy, beat, last_beat, ack_ok, abort, expired;

  wb_wide_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (hs | (cyc_q & wb_ack_i)),
    .enable_i (busy),
    .expired_o(expired)
  );

  always_comb begin
    n = we_q ? CW'(1) : CW'(NWORDS);
    hs = req_valid_i & (state_q == IDLE);
    busy = (state_q == ISSUE) | (state_q == WAIT);
    beat = stb_q & ~wb_stall_i;
    last_beat = beat & (iss_q + CW'(1) == n);
    // An ack coinciding with err/rty is treated as the error, so it neither counts nor stores data.
    ack_ok = cyc_q & wb_ack_i & ~wb_err_i & ~wb_rty_i & (ack_q < n);
    abort = cyc_q & (wb_err_i | wb_rty_i | expired);
    state_d = state_q;
    we_d = we_q;
    cyc_d = cyc_q;
    stb_d = stb_q;
    err_d = err_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    iss_d = iss_q;
    ack_d = ack_q;
    data_d = data_q;
    if (ack_ok) begin
      ack_d = ack_q + CW'(1);
      if (!we_q)
        for (int k = 0; k < NWORDS; k++)
          if (ack_q == CW'(k)) data_d[WORD_W*k +: WORD_W] = wb_dat_i;
    end
    if (beat) begin
      adr_d = adr_q + AW'(1);
      iss_d = iss_q + CW'(1);
      if (last_beat) stb_d = 1'b0;
    end
    case (state_q)
      IDLE: if (hs) begin
        state_d = ISSUE;
        we_d = req_we_i;
        adr_d = req_adr_i;
        dat_d = req_wdat_i;
        cyc_d = 1'b1;
        stb_d = 1'b1;
        sel_d = SEL_ALL;
        iss_d = '0;
        ack_d = '0;
        err_d = 1'b0;
      end
      ISSUE, WAIT: begin
        if (abort || ack_q == n) begin
          state_d = DONE;
          cyc_d = 1'b0;
          stb_d = 1'b0;
          sel_d = '0;
          err_d = abort;
        end else if (state_q == ISSUE && last_beat) begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      cyc_q <= 1'b0;
      stb_q <= 1'b0;
      err_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      iss_q <= '0;
      ack_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      cyc_q <= cyc_d;
      stb_q <= stb_d;
      err_q <= err_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      iss_q <= iss_d;
      ack_q <= ack_d;
      data_q <= data_d;
    end

  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == DONE;
  assign rsp_err_o = err_q;
  assign rsp_data_o = data_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;
endmodule

// File: tb/tb_wb_wide_reader.sv
// tb_wb_wide_reader: table-driven requests against a behavioural pipelined slave, scoreboarded responses.
module tb_wb_wide_reader;
  typedef struct {
    logic         err;
    logic [127:0] data;
  } rsp_t;
  typedef struct {
    logic        we;
    logic [5:0]  adr;
    logic [31:0] wdat;
    int          stall;
    int          err_at;
    bit          ack_en;
    bit          exp_err;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [5:0] req_adr = 0;
  logic [31:0] req_wdat = 0;
  logic rsp_valid, rsp_err;
  logic [127:0] rsp_data;
  logic wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_rty, wb_stall;
  logic [5:0] wb_adr;
  logic [3:0] wb_sel;
  logic [31:0] wb_dat_o, wb_dat_i;

  int checks = 0, failures = 0;
  int stall_n = 0, err_at = -1, stall_cnt = 0, beat_idx = 0;
  bit ack_en = 1;
  logic [31:0] mem [64];
  rsp_t sbq[$];
  logic [5:0] exp_adr[$];
  logic cur_we = 0;
  logic [31:0] cur_wdat = 0;
  logic [127:0] model_rsp = 0;
  rsp_t mon_e;
  vec_t vt[10];
  int lat;

  always #5 clk = ~clk;

  wb_wide_reader #(.ADDR_WIDTH(8), .NWORDS(4), .TIMEOUT(10)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_adr_i(req_adr), .req_wdat_i(req_wdat),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_rty_i(wb_rty), .wb_stall_i(wb_stall),
    .wb_dat_i(wb_dat_i)
  );

  // Slave: stalls stall_n cycles per beat, acks in the accepting cycle, or errs on beat err_at.
  wire acc = wb_cyc & wb_stb & ~wb_stall;
  assign wb_stall = wb_stb && (stall_cnt < stall_n);
  assign wb_err = acc && (beat_idx == err_at);
  assign wb_ack = acc && ack_en && !wb_err;
  assign wb_rty = 1'b0;
  assign wb_dat_i = mem[wb_adr];

  always @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i >= 32 && i < 36) ? 32'((i - 31) * 17) : 32'hC0DE_0000 + 32'(i);
      beat_idx <= 0;
      stall_cnt <= 0;
    end else if (!wb_cyc) begin
      beat_idx <= 0;
      stall_cnt <= 0;
    end else if (acc) begin
      beat_idx <= beat_idx + 1;
      stall_cnt <= 0;
      if (wb_we && wb_ack) mem[wb_adr] <= wb_dat_o;
    end else if (wb_stb) stall_cnt <= stall_cnt + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && rsp_valid) begin
      if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("rsp_err", rsp_err, mon_e.err);
        chk("rsp_data", rsp_data, mon_e.data);
        if (!mon_e.err) chk("beats_left", exp_adr.size(), 0);
      end
    end

  always @(negedge clk)
    if (rst_n && wb_cyc && wb_stb && !wb_stall) begin
      if (exp_adr.size() == 0) chk("beat_extra", 1, 0);
      else begin
        chk("beat_adr", wb_adr, exp_adr.pop_front());
        chk("beat_we", wb_we, cur_we);
        chk("beat_sel", wb_sel, 4'hF);
        if (cur_we) chk("beat_dat", wb_dat_o, cur_wdat);
      end
    end

  task automatic send(input logic we, input logic [5:0] adr, input logic [31:0] wdat, input bit push, input bit exp_err);
    rsp_t e;
    int n;
    logic [5:0] a;
    @(negedge clk);
    n = we ? 1 : 4;
    exp_adr.delete();
    for (int k = 0; k < n; k++) exp_adr.push_back(adr + 6'(k));
    cur_we = we;
    cur_wdat = wdat;
    e.err = exp_err;
    e.data = model_rsp;
    if (!we)
      for (int k = 0; k < 4; k++) begin
        a = adr + 6'(k);
        if (ack_en && (err_at < 0 || k < err_at)) e.data[32*k +: 32] = mem[a];
      end
    model_rsp = e.data;
    if (push) sbq.push_back(e);
    req_we = we;
    req_adr = adr;
    req_wdat = wdat;
    req_valid = 1;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("req_ready_wait", 0, 1);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("rsp_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clk);
    chk("rsp_pulse_end", rsp_valid, 0);
    chk("ready_after", req_ready, 1);
  endtask

  task automatic knobs(input int s, input int e, input bit a);
    stall_n = s;
    err_at = e;
    ack_en = a;
  endtask

  initial begin
    vt[0] = '{we:0, adr:6'h3E, wdat:0, stall:2, err_at:-1, ack_en:1, exp_err:0};
    vt[1] = '{we:1, adr:6'h05, wdat:32'hDEADBEEF, stall:0, err_at:-1, ack_en:1, exp_err:0};
    vt[2] = '{we:0, adr:6'h04, wdat:0, stall:1, err_at:-1, ack_en:1, exp_err:0};
    vt[3] = '{we:0, adr:6'h3F, wdat:0, stall:0, err_at:2, ack_en:1, exp_err:1};
    vt[4] = '{we:0, adr:6'h30, wdat:0, stall:0, err_at:0, ack_en:1, exp_err:1};
    vt[5] = '{we:1, adr:6'h3F, wdat:32'h12345678, stall:3, err_at:-1, ack_en:1, exp_err:0};
    vt[6] = '{we:0, adr:6'h3C, wdat:0, stall:0, err_at:-1, ack_en:1, exp_err:0};
    vt[7] = '{we:0, adr:6'h21, wdat:0, stall:1, err_at:-1, ack_en:1, exp_err:0};
    vt[8] = '{we:1, adr:6'h00, wdat:32'hA5A55A5A, stall:0, err_at:0, ack_en:1, exp_err:1};
    vt[9] = '{we:0, adr:6'h3E, wdat:0, stall:0, err_at:-1, ack_en:1, exp_err:0};

    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    // Zero-stall read: completion lands six cycles after the handshake.
    knobs(0, -1, 1);
    send(0, 6'h20, 0, 1, 0);
    for (lat = 1; lat <= 30; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("read_latency", lat, 6);
    chk("read_data_const", rsp_data, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("read_err", rsp_err, 0);
    wait_done();

    for (int i = 0; i < 10; i++) begin
      knobs(vt[i].stall, vt[i].err_at, vt[i].ack_en);
      send(vt[i].we, vt[i].adr, vt[i].wdat, 1, vt[i].exp_err);
      wait_done();
    end

    // Error on the second beat: cycle drops on the very next cycle.
    knobs(0, 1, 1);
    send(0, 6'h10, 0, 1, 1);
    for (int i = 0; i < 20 && !wb_err; i++) @(negedge clk);
    chk("err_seen", wb_err, 1);
    @(negedge clk);
    chk("err_cyc_drop", wb_cyc, 0);
    chk("err_stb_drop", wb_stb, 0);
    wait_done();

    // Silent slave: abort after ten idle cycles.
    knobs(0, -1, 0);
    send(0, 6'h08, 0, 1, 1);
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("timeout_latency", lat, 12);
    chk("timeout_err", rsp_err, 1);
    wait_done();

    // Reset while waiting for acks: bus released at once, no response.
    send(0, 6'h18, 0, 0, 0);
    repeat (6) @(negedge clk);
    chk("wait_cyc_high", wb_cyc, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_cyc", wb_cyc, 0);
    chk("rst_mid_valid", rsp_valid, 0);
    exp_adr.delete();
    model_rsp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (15) @(negedge clk);
    chk("rst_mid_ready", req_ready, 1);
    knobs(1, -1, 1);
    send(0, 6'h20, 0, 1, 0);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
